// File: rtl/regfile_dump_reader_if.sv
// Signal bundle between the register-file dump reader and its parent: control,
// file read port and the {index, value} output stream.
interface regfile_dump_reader_if #(
    parameter int IDX_W = 5,
    parameter int XLEN  = 64
) ();
    logic             start;
    logic [IDX_W-1:0] first_idx;
    logic [IDX_W-1:0] last_idx;
    logic             busy;
    logic             done;
    logic             rf_rd_req;
    logic [IDX_W-1:0] rf_rd_addr;
    logic [XLEN-1:0]  rf_rd_data;
    logic             dump_valid;
    logic             dump_ready;
    logic [IDX_W-1:0] dump_idx;
    logic [XLEN-1:0]  dump_data;

    modport master (
        input  start, first_idx, last_idx, rf_rd_data, dump_ready,
        output busy, done, rf_rd_req, rf_rd_addr, dump_valid, dump_idx, dump_data
    );

    modport slave (
        output start, first_idx, last_idx, rf_rd_data, dump_ready,
        input  busy, done, rf_rd_req, rf_rd_addr, dump_valid, dump_idx, dump_data
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks register indices first_idx..last_idx (wrapping at NUM_REGS-1), reads each one
// through the file read port and streams {index, value} beats, then pulses done.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = 5,
    parameter int XLEN     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_dump_reader_if.master bus,
    output logic [1:0]            dbg_state
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] cur, last;
    logic [IDX_W-1:0] cur_inc;
    logic             dump_valid_q;
    logic [IDX_W-1:0] dump_idx_q;
    logic [XLEN-1:0]  dump_data_q;
    logic             beat_fire;

    // Output stream: a beat transfers on a posedge where dump_valid && dump_ready;
    // once valid is raised, idx/data hold steady and valid stays high until that transfer.
    assign beat_fire = dump_valid_q && bus.dump_ready;
    assign cur_inc   = (cur == LAST_REG) ? '0 : cur + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start) state_next = ST_READ;
            ST_READ: state_next = ST_SEND;
            ST_SEND: if (beat_fire) state_next = (cur == last) ? ST_DONE : ST_READ;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur          <= '0;
            last         <= '0;
            dump_valid_q <= 1'b0;
            dump_idx_q   <= '0;
            dump_data_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        cur  <= bus.first_idx;
                        last <= bus.last_idx;
                    end
                end
                ST_READ: begin
                    // x0 is hardwired zero regardless of what the read port returns
                    dump_data_q  <= (cur == '0) ? '0 : bus.rf_rd_data;
                    dump_idx_q   <= cur;
                    dump_valid_q <= 1'b1;
                end
                ST_SEND: begin
                    if (beat_fire) begin
                        dump_valid_q <= 1'b0;
                        if (cur != last) cur <= cur_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = (state == ST_DONE);
    assign bus.rf_rd_req  = (state == ST_READ);
    assign bus.rf_rd_addr = (state == ST_READ) ? cur : '0;
    assign bus.dump_valid = dump_valid_q;
    assign bus.dump_idx   = dump_idx_q;
    assign bus.dump_data  = dump_data_q;
    assign dbg_state      = state;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: a register-file model drives the read port,
// stimulus pushes expected beats into a queue and a negedge monitor pops and compares.
module tb_regfile_dump_reader;
  localparam int IDX_W = 5;
  localparam int XLEN  = 64;
  localparam int BW    = IDX_W + XLEN;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  logic ready_drv;
  logic hold_idx3;
  logic [XLEN-1:0] rf_mem [32];
  logic [BW-1:0] exp_q[$];
  logic stall_v;
  logic [BW-1:0] stall_beat;
  int total;
  int bad;
  int done_cnt;
  int exp_done;
  int cyc;
  int done_before;

  regfile_dump_reader_if #(.IDX_W(IDX_W), .XLEN(XLEN)) bus ();

  regfile_dump_reader #(.NUM_REGS(32), .IDX_W(IDX_W), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.rf_rd_data = (bus.rf_rd_addr == '0) ? '0 : rf_mem[bus.rf_rd_addr];
  assign bus.dump_ready = ready_drv & ~(hold_idx3 & (bus.dump_idx == 5'd3));

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [XLEN-1:0] init_val(input int i);
    return (i == 0) ? 64'd0 : 64'h1000 + 64'(i);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dump(input int f, input int l);
    bus.first_idx = IDX_W'(f);
    bus.last_idx  = IDX_W'(l);
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic push_beat(input int i, input logic [XLEN-1:0] v);
    exp_q.push_back({IDX_W'(i), v});
  endtask

  task automatic push_range(input int f, input int l);
    int i;
    i = f;
    for (int k = 0; k < 32; k++) begin
      push_beat(i, init_val(i));
      if (i == l) break;
      i = (i + 1) % 32;
    end
  endtask

  task automatic wait_done(input int cnt0, output int cyc_out);
    bit found;
    found = 1'b0;
    cyc_out = cnt0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (bus.done) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cyc_out++;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL done_timeout: actual=no_done required=done");
    end
    tick();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      stall_v <= 1'b0;
    end else begin
      if (!bus.rf_rd_req) check("rd_addr_idle", 128'(bus.rf_rd_addr), 128'd0);
      if (stall_v) begin
        check("valid_held", 128'(bus.dump_valid), 128'd1);
        check("beat_stable", 128'({bus.dump_idx, bus.dump_data}), 128'(stall_beat));
      end
      if (bus.dump_valid && bus.dump_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: actual=idx%0d/%0h required=none",
                   bus.dump_idx, bus.dump_data);
        end else begin
          check("beat", 128'({bus.dump_idx, bus.dump_data}), 128'(exp_q.pop_front()));
        end
        stall_v <= 1'b0;
      end else if (bus.dump_valid) begin
        stall_v    <= 1'b1;
        stall_beat <= {bus.dump_idx, bus.dump_data};
      end else begin
        stall_v <= 1'b0;
      end
      if (bus.done) begin
        done_cnt <= done_cnt + 1;
        check("done_queue_empty", 128'(exp_q.size()), 128'd0);
      end
    end
  end

  initial begin
    total = 0; bad = 0; done_cnt = 0; exp_done = 0;
    stall_v = 1'b0; stall_beat = '0;
    for (int i = 0; i < 32; i++) rf_mem[i] = init_val(i);
    rst = 1'b1; ready_drv = 1'b0; hold_idx3 = 1'b0;
    bus.start = 1'b0; bus.first_idx = '0; bus.last_idx = '0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_req", 128'(bus.rf_rd_req), 128'd0);
    check("rst_valid", 128'(bus.dump_valid), 128'd0);
    check("rst_outs", 128'({bus.rf_rd_addr, bus.dump_idx, bus.dump_data}), 128'd0);
    check("rst_state", 128'(dbg_state), 128'd0);

    // 1) full dump 0..31, latency and throughput
    ready_drv = 1'b1;
    push_range(0, 31);
    start_dump(0, 31);
    @(negedge clk);
    check("t1_read_cycle", 128'({bus.busy, bus.rf_rd_req, bus.dump_valid}), 128'b110);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_first_valid", 128'({bus.dump_valid, bus.dump_idx}), 128'({1'b1, 5'd0}));
    @(posedge clk); #1;
    wait_done(2, cyc);
    exp_done++;
    check("t1_cycles", 128'(cyc), 128'd64);
    check("t1_idle_after", 128'(bus.busy), 128'd0);

    // 2) wrapping range 30..2
    push_range(30, 2);
    start_dump(30, 2);
    wait_done(0, cyc);
    exp_done++;
    check("t2_cycles", 128'(cyc), 128'd10);

    // 3) single beat stalled by consumer
    ready_drv = 1'b0;
    push_beat(5, 64'h1005);
    start_dump(5, 5);
    repeat (12) tick();
    check("t3_stalled", 128'({bus.dump_valid, bus.dump_idx, bus.dump_data}),
          128'({1'b1, 5'd5, 64'h1005}));
    ready_drv = 1'b1;
    wait_done(0, cyc);
    exp_done++;
    check("t3_done_after_hs", 128'(cyc), 128'd1);

    // 4) write while held, then re-dump
    ready_drv = 1'b0;
    push_beat(7, 64'h1007);
    start_dump(7, 7);
    tick();
    check("t4_held_valid", 128'(bus.dump_valid), 128'd1);
    rf_mem[7] = 64'hDEAD;
    repeat (3) tick();
    ready_drv = 1'b1;
    wait_done(0, cyc);
    exp_done++;
    push_beat(7, 64'hDEAD);
    start_dump(7, 7);
    wait_done(0, cyc);
    exp_done++;
    check("t4_cycles", 128'(cyc), 128'd2);
    rf_mem[7] = init_val(7);

    // 5a) start while busy is ignored
    push_range(10, 13);
    start_dump(10, 13);
    repeat (3) tick();
    bus.first_idx = '0; bus.last_idx = '0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(4, cyc);
    exp_done++;
    check("t5a_cycles", 128'(cyc), 128'd8);

    // 5b) reset during SEND of idx 3
    hold_idx3 = 1'b1;
    push_range(0, 2);
    start_dump(0, 31);
    for (int k = 0; k < 50; k++) begin
      if (bus.dump_valid && bus.dump_idx == 5'd3) break;
      tick();
    end
    repeat (2) tick();
    check("t5b_sending3", 128'({bus.dump_valid, bus.dump_idx}), 128'({1'b1, 5'd3}));
    done_before = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold_idx3 = 1'b0;
    check("t5b_outs_zero", 128'({bus.busy, bus.done, bus.rf_rd_req, bus.dump_valid,
          bus.rf_rd_addr, bus.dump_idx, bus.dump_data}), 128'd0);
    check("t5b_state_idle", 128'(dbg_state), 128'd0);
    repeat (10) tick();
    check("t5b_no_done", 128'(done_cnt), 128'(done_before));
    check("t5b_quiet", 128'({bus.busy, bus.dump_valid}), 128'd0);

    // rst and start together: rst wins
    bus.first_idx = 5'd1; bus.last_idx = 5'd1;
    bus.start = 1'b1; rst = 1'b1;
    tick();
    bus.start = 1'b0; rst = 1'b0;
    check("rst_wins", 128'({bus.busy, dbg_state}), 128'd0);
    tick();
    check("rst_wins_after", 128'(bus.busy), 128'd0);

    // 5c) fresh dump after reset
    push_range(2, 4);
    start_dump(2, 4);
    wait_done(0, cyc);
    exp_done++;
    check("t5c_cycles", 128'(cyc), 128'd6);

    repeat (4) tick();
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    check("done_count", 128'(done_cnt), 128'(exp_done));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
